crank_cam_gen: RTL and testbench

CRANK_CAM_GEN -- requirements
Module: crank_cam_gen

---
 rtl/crank_gen_pkg.sv | 12 +
 rtl/crank_tooth_timer.sv | 54 +++++
 rtl/crank_cam_gen.sv | 119 +++++++++++
 tb/tb_crank_cam_gen.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/crank_gen_pkg.sv
// Shared constants for the 60-2 crank / cam signal generator.
package crank_gen_pkg;

    localparam int TEETH_DEFAULT = 58;
    localparam int GAP_MULT      = 3;
    localparam int CAM_ON        = 4;
    localparam int CAM_OFF       = 54;
    localparam int CAM_TOGGLE    = 30;
    localparam int RESET_PERIOD  = 64;
    localparam int MIN_PERIOD    = 2;

endpackage

// File: rtl/crank_tooth_timer.sv
// Per-tooth tick counter: derives tooth length, the half-tooth vr_out level
// and the combinational wrap strobe on the last tick of a tooth.
module crank_tooth_timer
    import crank_gen_pkg::*;
#(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                is_gap,
    output logic                wrap,
    output logic                vr_out
);

    localparam int LW = PERIOD_W + 2;

    logic [LW-1:0] len;
    logic [LW-1:0] tck_q, tck_d, tck_inc;
    logic          vr_q, vr_d;

    // vr_d looks at the tick being entered, so vr_out tracks tck with no lag;
    // a wrap always enters tck 0, which is below half of any legal length.
    always_comb begin
        len     = is_gap ? LW'(period) * LW'(GAP_MULT) : LW'(period);
        tck_inc = tck_q + LW'(1);
        wrap    = en && (tck_q == len - LW'(1));
        tck_d   = tck_q;
        vr_d    = vr_q;
        if (en) begin
            if (wrap) begin
                tck_d = '0;
                vr_d  = 1'b0;
            end else begin
                tck_d = tck_inc;
                vr_d  = (tck_inc >= (len >> 1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tck_q <= '0;
            vr_q  <= 1'b0;
        end else begin
            tck_q <= tck_d;
            vr_q  <= vr_d;
        end
    end

    assign vr_out = vr_q;

endmodule

// File: rtl/crank_cam_gen.sv
// Crank/cam trigger-wheel generator top: tooth index, gap, rev and cam logic.
// Optional macro CRANK_GEN_RAMP_EN adds an acceleration sweep of the period.
module crank_cam_gen
    import crank_gen_pkg::*;
#(
    parameter int PERIOD_W = 16,
    parameter int TEETH    = TEETH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_wr,
`ifdef CRANK_GEN_RAMP_EN
    input  logic [PERIOD_W-1:0] ramp_step,
    input  logic [PERIOD_W-1:0] ramp_min,
`endif
    output logic                vr_out,
    output logic                cam_out,
    output logic [5:0]          tooth_idx,
    output logic                gap,
    output logic                rev_pulse,
    output logic                cam_phase
);

    logic [PERIOD_W-1:0] shadow_q, shadow_d;
    logic [PERIOD_W-1:0] p_q, p_d, p_load;
    logic [5:0]          tooth_idx_q, tooth_idx_d;
    logic                gap_q, gap_d;
    logic                rev_pulse_q, rev_pulse_d;
    logic                cam_phase_q, cam_phase_d;
    logic                cam_out_q, cam_out_d;
    logic                wrap;

    function automatic logic [PERIOD_W-1:0] clamp_min(input logic [PERIOD_W-1:0] v);
        return (v < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD) : v;
    endfunction

    crank_tooth_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .period (p_q),
        .is_gap (gap_q),
        .wrap   (wrap),
        .vr_out (vr_out)
    );

`ifdef CRANK_GEN_RAMP_EN
    logic                pending_q, pending_d;
    logic [PERIOD_W-1:0] ramp_dec, ramp_floor;

    // A write seen since the last wrap wins; otherwise step the period down.
    always_comb begin
        pending_d  = wrap ? period_wr : (pending_q | period_wr);
        ramp_dec   = (p_q > ramp_step) ? p_q - ramp_step : '0;
        ramp_floor = (ramp_dec > ramp_min) ? ramp_dec : ramp_min;
        p_load     = pending_q ? clamp_min(shadow_q) : clamp_min(ramp_floor);
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= 1'b0;
        else     pending_q <= pending_d;
    end
`else
    always_comb begin
        p_load = clamp_min(shadow_q);
    end
`endif

    always_comb begin
        shadow_d    = period_wr ? period : shadow_q;
        p_d         = p_q;
        tooth_idx_d = tooth_idx_q;
        gap_d       = gap_q;
        rev_pulse_d = rev_pulse_q;
        cam_phase_d = cam_phase_q;
        cam_out_d   = cam_out_q;
        if (en) begin
            rev_pulse_d = 1'b0;
            if (wrap) begin
                p_d         = p_load;
                tooth_idx_d = (tooth_idx_q == 6'(TEETH - 1)) ? '0 : tooth_idx_q + 6'd1;
                gap_d       = (tooth_idx_d == 6'(TEETH - 1));
                rev_pulse_d = (tooth_idx_d == '0);
                if (tooth_idx_d == 6'(CAM_TOGGLE)) cam_phase_d = ~cam_phase_q;
                if (cam_phase_q && tooth_idx_d == 6'(CAM_ON))  cam_out_d = 1'b1;
                if (cam_phase_q && tooth_idx_d == 6'(CAM_OFF)) cam_out_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q    <= PERIOD_W'(RESET_PERIOD);
            p_q         <= PERIOD_W'(RESET_PERIOD);
            tooth_idx_q <= '0;
            gap_q       <= 1'b0;
            rev_pulse_q <= 1'b0;
            cam_phase_q <= 1'b0;
            cam_out_q   <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            p_q         <= p_d;
            tooth_idx_q <= tooth_idx_d;
            gap_q       <= gap_d;
            rev_pulse_q <= rev_pulse_d;
            cam_phase_q <= cam_phase_d;
            cam_out_q   <= cam_out_d;
        end
    end

    assign tooth_idx = tooth_idx_q;
    assign gap       = gap_q;
    assign rev_pulse = rev_pulse_q;
    assign cam_phase = cam_phase_q;
    assign cam_out   = cam_out_q;

endmodule

// File: tb/tb_crank_cam_gen.sv
// Self-checking bench for crank_cam_gen: directed wheel scenarios plus
// randomized stimulus checked every clock against a behavioural wheel model.
module tb_crank_cam_gen;

    localparam int PERIOD_W = 16;
    localparam int TEETH    = 58;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic [PERIOD_W-1:0] period = '0;
    logic                period_wr = 1'b0;
    logic                vr_out, cam_out, gap, rev_pulse, cam_phase;
    logic [5:0]          tooth_idx;
`ifdef CRANK_GEN_RAMP_EN
    logic [PERIOD_W-1:0] ramp_step = '0;
    logic [PERIOD_W-1:0] ramp_min = '0;
`endif

    crank_cam_gen #(.PERIOD_W(PERIOD_W), .TEETH(TEETH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .period    (period),
        .period_wr (period_wr),
`ifdef CRANK_GEN_RAMP_EN
        .ramp_step (ramp_step),
        .ramp_min  (ramp_min),
`endif
        .vr_out    (vr_out),
        .cam_out   (cam_out),
        .tooth_idx (tooth_idx),
        .gap       (gap),
        .rev_pulse (rev_pulse),
        .cam_phase (cam_phase)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // wheel model state
    int m_tck, m_tooth, m_p, m_shadow;
    bit m_vr, m_cam, m_rev, m_phase;

    int tooth_len [TEETH];
    int prev_tooth = 0;
    int start_cyc  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit w, input int p);
        rst       = r;
        en        = e;
        period_wr = w;
        period    = PERIOD_W'(p);
    endtask

    // Wheel rules: tooth length P (3P on the last tooth), vr high from
    // half-tooth, P taken from the clamped shadow at each tooth boundary.
    task automatic model_step();
        int len;
        if (rst) begin
            m_tck = 0; m_tooth = 0; m_vr = 0; m_cam = 0; m_rev = 0; m_phase = 0;
            m_shadow = 64; m_p = 64;
        end else begin
            if (en) begin
                len = (m_tooth == TEETH - 1) ? 3 * m_p : m_p;
                if (m_tck == len - 1) begin
                    m_tck   = 0;
                    m_tooth = (m_tooth + 1) % TEETH;
                    m_p     = (m_shadow < 2) ? 2 : m_shadow;
                    m_rev   = (m_tooth == 0);
                    if (m_tooth == 30) m_phase = !m_phase;
                    if (m_phase && m_tooth == 4)  m_cam = 1;
                    if (m_phase && m_tooth == 54) m_cam = 0;
                end else begin
                    m_tck++;
                    m_rev = 0;
                end
                len  = (m_tooth == TEETH - 1) ? 3 * m_p : m_p;
                m_vr = (m_tck >= len / 2);
            end
            if (period_wr) m_shadow = int'(period);
        end
    endtask

    task automatic tick();
        logic [10:0] e;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
        e = {m_vr, m_cam, (m_tooth == TEETH - 1), m_rev, m_phase, 6'(m_tooth)};
        checkOutput("outs", {21'd0, vr_out, cam_out, gap, rev_pulse, cam_phase, tooth_idx},
                    {21'd0, e});
        if (rst) begin
            prev_tooth = 0;
            start_cyc  = cyc;
        end else if (int'(tooth_idx) != prev_tooth) begin
            tooth_len[prev_tooth] = cyc - start_cyc;
            prev_tooth = int'(tooth_idx);
            start_cyc  = cyc;
        end
    endtask

    task automatic wait_tooth(input int t, input string tag);
        int n = 0;
        while (int'(tooth_idx) != t && n < 5000) begin
            tick();
            n++;
        end
        checkOutput(tag, 32'(tooth_idx), 32'(t));
    endtask

    initial begin
        int r_seen, r1, r2, gap_cnt, vr57, rel_cyc, last_idx, n;
        logic ph30 [2];
        logic cam4 [2];
        r_seen = 0; r1 = 0; r2 = 0; gap_cnt = 0; vr57 = 0; last_idx = 0;
        ph30[0] = 1'bx; ph30[1] = 1'bx; cam4[0] = 1'bx; cam4[1] = 1'bx;

        // reset state
        applyStimulus(1, 1, 1, 5);
        tick();
        tick();
        checkOutput("rst_tooth", 32'(tooth_idx), 0);
        checkOutput("rst_vr",    32'(vr_out), 0);
        checkOutput("rst_cam",   32'(cam_out), 0);
        checkOutput("rst_gap",   32'(gap), 0);
        checkOutput("rst_rev",   32'(rev_pulse), 0);
        checkOutput("rst_phase", 32'(cam_phase), 0);
        rel_cyc = cyc;
        applyStimulus(0, 1, 0, 0);

        // two full revolutions at the default period
        for (int i = 0; i < 8000 && r_seen < 2; i++) begin
            tick();
            if (rev_pulse) begin
                r_seen++;
                if (r_seen == 1) r1 = cyc;
                else             r2 = cyc;
            end
            if (r_seen == 0 && gap) begin
                gap_cnt++;
                if (vr_out) vr57++;
            end
            if (r_seen < 2 && int'(tooth_idx) == 30 && last_idx != 30) ph30[r_seen] = cam_phase;
            if (r_seen < 2 && int'(tooth_idx) == 4  && last_idx != 4)  cam4[r_seen] = cam_out;
            last_idx = int'(tooth_idx);
        end
        checkOutput("rev_wait",    32'(r_seen), 2);
        checkOutput("rev_latency", 32'(r1 - rel_cyc), 3840);
        checkOutput("rev_period",  32'(r2 - r1), 3840);
        checkOutput("gap_clks",    32'(gap_cnt), 192);
        checkOutput("gap_vr_high", 32'(vr57), 96);
        checkOutput("phase_t30_r1", 32'(ph30[0]), 1);
        checkOutput("phase_t30_r2", 32'(ph30[1]), 0);
        checkOutput("cam_t4_r1",   32'(cam4[0]), 0);
        checkOutput("cam_t4_r2",   32'(cam4[1]), 1);

        // period write mid-tooth 5 takes effect on tooth 6
        n = 0;
        while (!(m_tooth == 5 && m_tck == 10) && n < 5000) begin
            tick();
            n++;
        end
        checkOutput("wait_t5", 32'(tooth_idx), 5);
        applyStimulus(0, 1, 1, 100);
        tick();
        applyStimulus(0, 1, 0, 100);
        wait_tooth(7, "wait_t7");
        checkOutput("len_t5", 32'(tooth_len[5]), 64);
        checkOutput("len_t6", 32'(tooth_len[6]), 100);

        // period 0 clamps to 2; a write on the wrap clock lands one tooth later
        applyStimulus(0, 1, 1, 0);
        tick();
        applyStimulus(0, 1, 0, 0);
        wait_tooth(8, "wait_t8");
        checkOutput("t8_vr0", 32'(vr_out), 0);
        tick();
        checkOutput("t8_vr1",    32'(vr_out), 1);
        checkOutput("t8_still",  32'(tooth_idx), 8);
        applyStimulus(0, 1, 1, 64);
        tick();
        applyStimulus(0, 1, 0, 64);
        checkOutput("t9_enter", 32'(tooth_idx), 9);
        wait_tooth(11, "wait_t11");
        checkOutput("len_t8",  32'(tooth_len[8]), 2);
        checkOutput("len_t9",  32'(tooth_len[9]), 2);
        checkOutput("len_t10", 32'(tooth_len[10]), 64);

        // freeze for 50 clocks at tck 20
        n = 0;
        while (m_tck != 20 && n < 200) begin
            tick();
            n++;
        end
        applyStimulus(0, 0, 0, 64);
        repeat (50) tick();
        checkOutput("freeze_tooth", 32'(tooth_idx), 11);
        checkOutput("freeze_vr",    32'(vr_out), 0);
        applyStimulus(0, 1, 0, 64);
        n = 0;
        while (int'(tooth_idx) == 11 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("resume_clks", 32'(n), 44);

        // randomized enable / period writes / occasional reset
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 999) == 0),
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 49) == 0),
                          int'($urandom_range(0, 12)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
